// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA timing path.
// Holds FSM state, channel-mode field layout and a mode packing helper.
package dma_pkg;

    localparam int NCH    = 4;
    localparam int MODE_W = 6;
    localparam int TT_LSB = 0;
    localparam int AI_BIT = 2;
    localparam int AD_BIT = 3;
    localparam int TM_LSB = 4;

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} TimingState_t;

    typedef enum logic [1:0] {
        SINGLE, BLOCK, DEMAND, CASCADE
    } TransferMode_t;

    typedef enum logic [1:0] {
        VERIFY, WRITE, READ, ILLEGAL
    } TransferType_t;

    typedef struct packed {
        TransferMode_t mode;
        logic          addr_dec;
        logic          auto_init;
        TransferType_t ttype;
    } ChMode_t;

    function automatic logic [MODE_W-1:0] mode_bits(
        input TransferMode_t m,
        input logic          ad,
        input logic          ai,
        input TransferType_t t
    );
        logic [MODE_W-1:0] v;
        v = '0;
        v[TM_LSB +: 2] = m;
        v[AD_BIT]      = ad;
        v[AI_BIT]      = ai;
        v[TT_LSB +: 2] = t;
        return v;
    endfunction

endpackage

// File: rtl/dma_timing_control_if.sv
// Bus-side signals of the DMA timing controller: hold handshake,
// address, strobes and end-of-process. master = DMA, slave = bus/CPU.
interface dma_timing_control_if #(
    parameter int AW = 16
);
    logic          Hrq;
    logic          Hlda;
    logic          Aen;
    logic          Adstb;
    logic [AW-1:0] Address;
    logic          Memr_n;
    logic          Memw_n;
    logic          Ior_n;
    logic          Iow_n;
    logic          Eop_n;
    logic          EopIn_n;

    modport master (
        output Hrq, Aen, Adstb, Address,
        output Memr_n, Memw_n, Ior_n, Iow_n, Eop_n,
        input  Hlda, EopIn_n
    );

    modport slave (
        input  Hrq, Aen, Adstb, Address,
        input  Memr_n, Memw_n, Ior_n, Iow_n, Eop_n,
        output Hlda, EopIn_n
    );
endinterface

// File: rtl/dma_channel_counters.sv
// Per-channel base/current address and word-count registers.
// Ports: ProgLoad/ProgAddr/ProgCount load, Update/UpdCh/AddrDec/Reload step.
module dma_channel_counters #(
    parameter int AW  = 16,
    parameter int NCH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NCH-1:0]           ProgLoad,
    input  logic [AW-1:0]            ProgAddr,
    input  logic [AW-1:0]            ProgCount,
    input  logic                     Update,
    input  logic [$clog2(NCH)-1:0]   UpdCh,
    input  logic                     AddrDec,
    input  logic                     Reload,
    output logic [NCH-1:0][AW-1:0]   CurrAddr,
    output logic [NCH-1:0][AW-1:0]   CurrCount
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0][AW-1:0] base_addr;
    logic [NCH-1:0][AW-1:0] base_count;

    // A programming load beats a same-cycle transfer update.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            base_addr  <= '0;
            base_count <= '0;
            CurrAddr   <= '0;
            CurrCount  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ProgLoad[i]) begin
                    base_addr[i]  <= ProgAddr;
                    base_count[i] <= ProgCount;
                    CurrAddr[i]   <= ProgAddr;
                    CurrCount[i]  <= ProgCount;
                end else if (Update && UpdCh == CW'(i)) begin
                    if (Reload) begin
                        CurrAddr[i]  <= base_addr[i];
                        CurrCount[i] <= base_count[i];
                    end else begin
                        CurrAddr[i]  <= AddrDec ? CurrAddr[i] - 1'b1
                                                : CurrAddr[i] + 1'b1;
                        CurrCount[i] <= CurrCount[i] - 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/dma_timing_control.sv
// 8237-style transfer timing: hold handshake, S1-S4 cycles, strobes, TC/EOP.
// Ports: grant in, mode/program in, Bus (master), TcPulse and Busy out.
module dma_timing_control #(
    parameter int AW  = 16,
    parameter int NCH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ValidReqID,
    input  logic [$clog2(NCH)-1:0] ReqID,
    input  logic [NCH-1:0]         PendingReq,
    input  logic [NCH*6-1:0]       ChMode,
    input  logic [NCH-1:0]         ProgLoad,
    input  logic [AW-1:0]          ProgAddr,
    input  logic [AW-1:0]          ProgCount,
    dma_timing_control_if.master   Bus,
    output logic [NCH-1:0]         TcPulse,
    output logic                   Busy
);
    import dma_pkg::*;

    localparam int CW = $clog2(NCH);

    localparam logic [2:0] ST_SI = 3'(SI);
    localparam logic [2:0] ST_S0 = 3'(S0);
    localparam logic [2:0] ST_S1 = 3'(S1);
    localparam logic [2:0] ST_S2 = 3'(S2);
    localparam logic [2:0] ST_S3 = 3'(S3);
    localparam logic [2:0] ST_S4 = 3'(S4);

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [CW-1:0]          chan;
    logic                   eop_seen;
    ChMode_t                mode;
    logic [NCH-1:0][AW-1:0] curr_addr;
    logic [NCH-1:0][AW-1:0] curr_count;
    logic                   in_xfer;
    logic                   in_s4;
    logic                   rd_act;
    logic                   wr_act;
    logic                   tc;
    logic                   term;

    assign mode    = ChMode_t'(ChMode[chan*MODE_W +: MODE_W]);
    assign in_xfer = (state == ST_S1) || (state == ST_S2) ||
                     (state == ST_S3) || (state == ST_S4);
    assign in_s4   = (state == ST_S4);
    assign rd_act  = (state == ST_S2) || (state == ST_S3) || in_s4;
    assign wr_act  = (state == ST_S3) || in_s4;

    // Count is still the pre-update value while in S4.
    assign tc   = in_s4 && (curr_count[chan] == '0);
    assign term = tc || (in_s4 && (eop_seen || !Bus.EopIn_n));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_SI: if (ValidReqID && !Bus.Hlda) state_nxt = ST_S0;
            ST_S0: if (Bus.Hlda) state_nxt = ST_S1;
            ST_S1: state_nxt = Bus.Hlda ? ST_S2 : ST_SI;
            ST_S2: state_nxt = Bus.Hlda ? ST_S3 : ST_SI;
            ST_S3: state_nxt = Bus.Hlda ? ST_S4 : ST_SI;
            ST_S4: begin
                unique case (mode.mode)
                    BLOCK:   state_nxt = term ? ST_SI : ST_S1;
                    DEMAND:  state_nxt = (PendingReq[chan] && !term)
                                         ? ST_S1 : ST_SI;
                    default: state_nxt = ST_SI;
                endcase
            end
            default: state_nxt = ST_SI;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_SI;
            chan     <= '0;
            eop_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_SI && state_nxt == ST_S0)
                chan <= ReqID;
            // External EOP is remembered per transfer until its S4.
            if (!in_xfer || in_s4 || state_nxt == ST_SI)
                eop_seen <= 1'b0;
            else if (!Bus.EopIn_n)
                eop_seen <= 1'b1;
        end
    end

    dma_channel_counters #(
        .AW  (AW),
        .NCH (NCH)
    ) u_cnt (
        .Clock     (Clock),
        .Reset     (Reset),
        .ProgLoad  (ProgLoad),
        .ProgAddr  (ProgAddr),
        .ProgCount (ProgCount),
        .Update    (in_s4),
        .UpdCh     (chan),
        .AddrDec   (mode.addr_dec),
        .Reload    (term && mode.auto_init),
        .CurrAddr  (curr_addr),
        .CurrCount (curr_count)
    );

    assign Busy        = (state != ST_SI);
    assign Bus.Hrq     = (state != ST_SI);
    assign Bus.Aen     = in_xfer;
    assign Bus.Adstb   = (state == ST_S1);
    assign Bus.Address = in_xfer ? curr_addr[chan] : '0;
    assign Bus.Memr_n  = !(rd_act && mode.ttype == READ);
    assign Bus.Iow_n   = !(wr_act && mode.ttype == READ);
    assign Bus.Ior_n   = !(rd_act && mode.ttype == WRITE);
    assign Bus.Memw_n  = !(wr_act && mode.ttype == WRITE);
    assign Bus.Eop_n   = !tc;

    always_comb begin
        TcPulse = '0;
        if (term) TcPulse[chan] = 1'b1;
    end
endmodule

// File: tb/tb_dma_timing_control.sv
// Directed bench for dma_timing_control.
// Walks transfers cycle by cycle against hand-computed values.
module tb_dma_timing_control;
    import dma_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        ValidReqID;
    logic [1:0]  ReqID;
    logic [3:0]  PendingReq;
    logic [23:0] ChMode;
    logic [3:0]  ProgLoad;
    logic [15:0] ProgAddr;
    logic [15:0] ProgCount;
    logic [3:0]  TcPulse;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    dma_timing_control_if #(.AW(16)) bus ();

    dma_timing_control #(.AW(16), .NCH(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ValidReqID (ValidReqID),
        .ReqID      (ReqID),
        .PendingReq (PendingReq),
        .ChMode     (ChMode),
        .ProgLoad   (ProgLoad),
        .ProgAddr   (ProgAddr),
        .ProgCount  (ProgCount),
        .Bus        (bus),
        .TcPulse    (TcPulse),
        .Busy       (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int ch, input logic [15:0] a,
                        input logic [15:0] c);
        ProgLoad = 4'(1 << ch);
        ProgAddr = a;
        ProgCount = c;
        tick();
        ProgLoad = '0;
    endtask

    // Grant in SI, Hlda answered one cycle after Hrq; ends in S1.
    task automatic start(input logic [1:0] ch);
        ValidReqID = 1'b1;
        ReqID = ch;
        tick();
        ValidReqID = 1'b0;
        bus.Hlda = 1'b1;
        tick();
    endtask

    task automatic strobes(input string tag, input logic [3:0] exp);
        chk(tag, {bus.Memr_n, bus.Iow_n, bus.Ior_n, bus.Memw_n}, exp);
    endtask

    initial begin
        Reset = 1'b1;
        ValidReqID = 1'b0;
        ReqID = '0;
        PendingReq = '0;
        ChMode = '0;
        ProgLoad = '0;
        ProgAddr = '0;
        ProgCount = '0;
        bus.Hlda = 1'b0;
        bus.EopIn_n = 1'b1;
        tick();
        tick();
        chk("rst_hrq", bus.Hrq, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_aen", {bus.Aen, bus.Adstb}, 0);
        chk("rst_addr", bus.Address, 0);
        strobes("rst_strb", 4'hF);
        chk("rst_eop", bus.Eop_n, 1);
        chk("rst_tc", TcPulse, 0);
        Reset = 1'b0;

        // Read, single mode, ch1
        ChMode[11:6] = mode_bits(SINGLE, 1'b0, 1'b0, READ);
        prog(1, 16'h1000, 16'd2);
        ValidReqID = 1'b1;
        ReqID = 2'd1;
        tick();
        ValidReqID = 1'b0;
        chk("t1_s0_hrq", bus.Hrq, 1);
        chk("t1_s0_aen", bus.Aen, 0);
        tick();
        chk("t1_s0_wait", {bus.Hrq, bus.Aen}, 2'b10);
        bus.Hlda = 1'b1;
        tick();
        chk("t1_s1_ctl", {bus.Aen, bus.Adstb}, 2'b11);
        chk("t1_s1_addr", bus.Address, 16'h1000);
        strobes("t1_s1_strb", 4'hF);
        tick();
        strobes("t1_s2_strb", 4'b0111);
        tick();
        strobes("t1_s3_strb", 4'b0011);
        tick();
        strobes("t1_s4_strb", 4'b0011);
        chk("t1_s4_eop", {bus.Eop_n, TcPulse}, 5'b1_0000);
        tick();
        chk("t1_end_hrq", bus.Hrq, 0);
        strobes("t1_end_strb", 4'hF);
        chk("t1_addr", dut.curr_addr[1], 16'h1001);
        chk("t1_count", dut.curr_count[1], 16'd1);
        bus.Hlda = 1'b0;
        tick();

        // Write, block mode, decrementing, ch2
        ChMode[17:12] = mode_bits(BLOCK, 1'b1, 1'b0, WRITE);
        prog(2, 16'h0002, 16'd2);
        start(2'd2);
        for (int k = 0; k < 3; k++) begin
            chk("t2_s1_addr", bus.Address, 32'(2 - k));
            chk("t2_s1_adstb", bus.Adstb, 1);
            tick();
            strobes("t2_s2_strb", 4'b1101);
            tick();
            strobes("t2_s3_strb", 4'b1100);
            tick();
            chk("t2_s4_eop", bus.Eop_n, (k == 2) ? 0 : 1);
            chk("t2_s4_tc", TcPulse, (k == 2) ? 4'b0100 : 4'b0000);
            tick();
        end
        chk("t2_end_hrq", bus.Hrq, 0);
        chk("t2_addr", dut.curr_addr[2], 16'hFFFF);
        chk("t2_count", dut.curr_count[2], 16'hFFFF);
        bus.Hlda = 1'b0;
        tick();

        // Demand mode, ch0
        ChMode[5:0] = mode_bits(DEMAND, 1'b0, 1'b0, READ);
        prog(0, 16'h3000, 16'd9);
        PendingReq = 4'b0001;
        start(2'd0);
        chk("t3_x1_addr", bus.Address, 16'h3000);
        tick();
        tick();
        tick();
        chk("t3_x1_tc", TcPulse, 0);
        tick();
        chk("t3_x2_addr", bus.Address, 16'h3001);
        chk("t3_x2_adstb", bus.Adstb, 1);
        tick();
        PendingReq = 4'b0000;
        tick();
        tick();
        chk("t3_x2_tc", {bus.Eop_n, TcPulse}, 5'b1_0000);
        tick();
        chk("t3_end_hrq", bus.Hrq, 0);
        chk("t3_count", dut.curr_count[0], 16'd7);
        bus.Hlda = 1'b0;
        tick();

        // Autoinit at TC, verify type, ch3
        ChMode[23:18] = mode_bits(SINGLE, 1'b0, 1'b1, VERIFY);
        prog(3, 16'h2000, 16'd0);
        start(2'd3);
        chk("t4_s1_addr", bus.Address, 16'h2000);
        tick();
        strobes("t4_s2_strb", 4'hF);
        tick();
        tick();
        chk("t4_s4_eop", bus.Eop_n, 0);
        chk("t4_s4_tc", TcPulse, 4'b1000);
        tick();
        chk("t4_end_hrq", bus.Hrq, 0);
        chk("t4_addr", dut.curr_addr[3], 16'h2000);
        chk("t4_count", dut.curr_count[3], 16'd0);
        bus.Hlda = 1'b0;
        tick();

        // External EOP, block mode, ch1
        ChMode[11:6] = mode_bits(BLOCK, 1'b0, 1'b0, READ);
        prog(1, 16'h4000, 16'h00FF);
        start(2'd1);
        tick();
        tick();
        tick();
        chk("t5_x1_tc", {bus.Eop_n, TcPulse}, 5'b1_0000);
        tick();
        chk("t5_x2_addr", bus.Address, 16'h4001);
        tick();
        bus.EopIn_n = 1'b0;
        chk("t5_s2_eop", bus.Eop_n, 1);
        tick();
        bus.EopIn_n = 1'b1;
        chk("t5_s3_eop", bus.Eop_n, 1);
        tick();
        chk("t5_s4_tc", TcPulse, 4'b0010);
        chk("t5_s4_eop", bus.Eop_n, 1);
        tick();
        chk("t5_end_hrq", bus.Hrq, 0);
        chk("t5_count", dut.curr_count[1], 16'h00FD);
        bus.Hlda = 1'b0;
        tick();

        // Hlda dropped in S2 aborts, ch2
        ChMode[17:12] = mode_bits(SINGLE, 1'b0, 1'b0, READ);
        prog(2, 16'h5000, 16'd5);
        start(2'd2);
        tick();
        strobes("t6_s2_strb", 4'b0111);
        bus.Hlda = 1'b0;
        tick();
        chk("t6_ab_hrq", {bus.Hrq, bus.Aen}, 2'b00);
        strobes("t6_ab_strb", 4'hF);
        chk("t6_ab_addr", dut.curr_addr[2], 16'h5000);
        chk("t6_ab_count", dut.curr_count[2], 16'd5);

        // Reset asserted in S3
        start(2'd2);
        tick();
        tick();
        strobes("t7_s3_strb", 4'b0011);
        Reset = 1'b1;
        tick();
        chk("t7_rst_ctl", {bus.Hrq, Busy, bus.Aen, bus.Adstb}, 4'b0000);
        strobes("t7_rst_strb", 4'hF);
        chk("t7_rst_addr", bus.Address, 0);
        chk("t7_rst_eop", {bus.Eop_n, TcPulse}, 5'b1_0000);
        chk("t7_rst_cnt", dut.curr_count[2], 0);
        Reset = 1'b0;
        bus.Hlda = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
